// File: rtl/vga_obj_renderer.sv
// VGA timing generator with an N-object rectangle compositor.
// Object config is double-buffered and committed at the end of each frame.
module vga_obj_renderer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int N_OBJ    = 4,
    parameter int CW       = 8,
    localparam int OAW     = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [OAW+1:0]    cfg_addr,
    input  logic [31:0]       cfg_wdata,
    input  logic [3*CW-1:0]   bg_color,
    output logic              vga_clk_out,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_blank_n,
    output logic [CW-1:0]     vga_r,
    output logic [CW-1:0]     vga_g,
    output logic [CW-1:0]     vga_b,
    output logic              frame_start
);

    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
    localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    // Forwarded clock is inverted so the DAC samples mid-pixel.
    assign vga_clk_out = ~vga_clk;

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        frame_end;

    assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    logic [N_OBJ-1:0] hit;
    logic [3*CW-1:0]  obj_col [N_OBJ];

    logic unused_wdata;
    assign unused_wdata = ^cfg_wdata;

    for (genvar g = 0; g < N_OBJ; g++) begin : g_obj
        logic            wr;
        logic [11:0]     sh_x, sh_y, sh_w, sh_h;
        logic [3*CW-1:0] sh_c;
        logic            sh_en;
        logic [11:0]     ac_x, ac_y, ac_w, ac_h;
        logic [3*CW-1:0] ac_c;
        logic            ac_en;
        logic            in_x, in_y;

        // Out-of-range indices match no object and are dropped.
        assign wr = cfg_we && (cfg_addr[OAW+1:2] == OAW'(g));

        always_ff @(posedge vga_clk) begin
            if (rst) begin
                sh_x  <= '0;
                sh_y  <= '0;
                sh_w  <= '0;
                sh_h  <= '0;
                sh_c  <= '0;
                sh_en <= 1'b0;
            end else if (wr) begin
                unique case (cfg_addr[1:0])
                    2'd0: begin
                        sh_x <= cfg_wdata[27:16];
                        sh_y <= cfg_wdata[11:0];
                    end
                    2'd1: begin
                        sh_w <= cfg_wdata[27:16];
                        sh_h <= cfg_wdata[11:0];
                    end
                    2'd2: sh_c  <= cfg_wdata[3*CW-1:0];
                    2'd3: sh_en <= cfg_wdata[0];
                endcase
            end
        end

        always_ff @(posedge vga_clk) begin
            if (rst) begin
                ac_x  <= '0;
                ac_y  <= '0;
                ac_w  <= '0;
                ac_h  <= '0;
                ac_c  <= '0;
                ac_en <= 1'b0;
            end else if (frame_end) begin
                ac_x  <= sh_x;
                ac_y  <= sh_y;
                ac_w  <= sh_w;
                ac_h  <= sh_h;
                ac_c  <= sh_c;
                ac_en <= sh_en;
            end
        end

        // 13-bit end coordinates keep x+w from wrapping back to 0.
        assign in_x = ({1'b0, h_cnt} >= {1'b0, ac_x}) &&
                      ({1'b0, h_cnt} < ({1'b0, ac_x} + {1'b0, ac_w}));
        assign in_y = ({1'b0, v_cnt} >= {1'b0, ac_y}) &&
                      ({1'b0, v_cnt} < ({1'b0, ac_y} + {1'b0, ac_h}));

        assign hit[g]     = ac_en && in_x && in_y;
        assign obj_col[g] = ac_c;
    end

    logic [N_OBJ-1:0] s1_hit;
    logic             s1_act;
    logic             s1_hs;
    logic             s1_vs;
    logic             s1_fs;

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            s1_hit <= '0;
            s1_act <= 1'b0;
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            s1_fs  <= 1'b0;
        end else begin
            s1_hit <= hit;
            s1_act <= (h_cnt < H_ACT) && (v_cnt < V_ACT);
            s1_hs  <= (h_cnt >= HS_BEG) && (h_cnt < HS_END);
            s1_vs  <= (v_cnt >= VS_BEG) && (v_cnt < VS_END);
            s1_fs  <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
        end
    end

    logic [3*CW-1:0] pix;

    // Scan downwards so the lowest-index hit overrides the rest.
    always_comb begin
        pix = bg_color;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (s1_hit[i]) begin
                pix = obj_col[i];
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            vga_hsync   <= ~HS_POL;
            vga_vsync   <= ~VS_POL;
            vga_blank_n <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            frame_start <= 1'b0;
        end else begin
            vga_hsync   <= s1_hs ? HS_POL : ~HS_POL;
            vga_vsync   <= s1_vs ? VS_POL : ~VS_POL;
            vga_blank_n <= s1_act;
            vga_r       <= s1_act ? pix[3*CW-1:2*CW] : '0;
            vga_g       <= s1_act ? pix[2*CW-1:CW]   : '0;
            vga_b       <= s1_act ? pix[CW-1:0]      : '0;
            frame_start <= s1_fs;
        end
    end

endmodule

// File: tb/tb_vga_obj_renderer.sv
// Directed bench for vga_obj_renderer on a 14x7 toy timing.
// Each frame is scanned pixel by pixel against hand-stated rectangles.
module tb_vga_obj_renderer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic [23:0] bg_color = 24'h102030;
    logic        vga_clk_out;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_blank_n;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        frame_start;

    vga_obj_renderer #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0),
        .N_OBJ(2), .CW(8)
    ) dut (
        .vga_clk(clk),
        .rst(rst),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata),
        .bg_color(bg_color),
        .vga_clk_out(vga_clk_out),
        .vga_hsync(vga_hsync),
        .vga_vsync(vga_vsync),
        .vga_blank_n(vga_blank_n),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          e_en [2];
    int          e_x  [2];
    int          e_y  [2];
    int          e_w  [2];
    int          e_h  [2];
    logic [23:0] e_c  [2];

    int          wq_p [$];
    logic [2:0]  wq_a [$];
    logic [31:0] wq_d [$];

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic q_wr(input int p, input logic [2:0] a, input logic [31:0] d);
        wq_p.push_back(p);
        wq_a.push_back(a);
        wq_d.push_back(d);
    endtask

    function automatic logic [23:0] exp_rgb(input int x, input int y);
        if (!(x < 8 && y < 4)) return 24'h0;
        for (int i = 0; i < 2; i++) begin
            if (e_en[i] != 0 && x >= e_x[i] && x < e_x[i] + e_w[i] &&
                y >= e_y[i] && y < e_y[i] + e_h[i])
                return e_c[i];
        end
        return bg_color;
    endfunction

    task automatic set_obj(input int i, input int en, input int x, input int y,
                           input int w, input int h, input logic [23:0] c);
        e_en[i] = en;
        e_x[i]  = x;
        e_y[i]  = y;
        e_w[i]  = w;
        e_h[i]  = h;
        e_c[i]  = c;
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, " blank_n"}, 32'(vga_blank_n), 32'd0);
        check_eq({tag, " hsync"}, 32'(vga_hsync), 32'd1);
        check_eq({tag, " vsync"}, 32'(vga_vsync), 32'd1);
        check_eq({tag, " rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
        check_eq({tag, " frame_start"}, 32'(frame_start), 32'd0);
    endtask

    // Pixel p of the frame is on the pins one sample after each step.
    task automatic run_frame(input string tag, input int n);
        for (int p = 0; p < n; p++) begin
            int   x;
            int   y;
            logic act;
            step();
            x   = p % 14;
            y   = p / 14;
            act = (x < 8) && (y < 4);
            check_eq($sformatf("%s p%0d blank_n", tag, p),
                     32'(vga_blank_n), 32'(act));
            check_eq($sformatf("%s p%0d rgb", tag, p),
                     32'({vga_r, vga_g, vga_b}), 32'(exp_rgb(x, y)));
            check_eq($sformatf("%s p%0d hsync", tag, p),
                     32'(vga_hsync), 32'(!(x == 10 || x == 11)));
            check_eq($sformatf("%s p%0d vsync", tag, p),
                     32'(vga_vsync), 32'(y != 5));
            check_eq($sformatf("%s p%0d frame_start", tag, p),
                     32'(frame_start), 32'(p == 0));
            if (wq_p.size() > 0 && wq_p[0] == p) begin
                cfg_we    = 1'b1;
                cfg_addr  = wq_a.pop_front();
                cfg_wdata = wq_d.pop_front();
                void'(wq_p.pop_front());
            end else begin
                cfg_we = 1'b0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) set_obj(i, 0, 0, 0, 0, 0, 24'h0);

        step();
        step();
        step();
        check_reset("por");
        rst = 1'b0;
        step();

        q_wr(10, 3'b000, (32'd2 << 16) | 32'd1);
        q_wr(11, 3'b001, (32'd3 << 16) | 32'd2);
        q_wr(12, 3'b010, 32'h00FF0000);
        q_wr(13, 3'b011, 32'd1);
        run_frame("f0_bg", 98);

        set_obj(0, 1, 2, 1, 3, 2, 24'hFF0000);
        q_wr(20, 3'b100, (32'd3 << 16) | 32'd0);
        q_wr(21, 3'b101, (32'd4 << 16) | 32'd4);
        q_wr(22, 3'b110, 32'h0000FF00);
        q_wr(23, 3'b111, 32'd1);
        q_wr(95, 3'b010, 32'h000000FF);
        run_frame("f1_single", 98);

        set_obj(1, 1, 3, 0, 4, 4, 24'h00FF00);
        run_frame("f2_prio", 98);

        set_obj(0, 1, 2, 1, 3, 2, 24'h0000FF);
        q_wr(30, 3'b111, 32'd0);
        q_wr(31, 3'b000, (32'd6 << 16) | 32'd1);
        q_wr(32, 3'b001, (32'd4090 << 16) | 32'd2);
        run_frame("f3_commit", 98);

        set_obj(1, 0, 3, 0, 4, 4, 24'h00FF00);
        set_obj(0, 1, 6, 1, 4090, 2, 24'h0000FF);
        q_wr(40, 3'b001, (32'd0 << 16) | 32'd2);
        run_frame("f4_clip", 98);

        set_obj(0, 1, 6, 1, 0, 2, 24'h0000FF);
        q_wr(40, 3'b001, (32'd3 << 16) | 32'd2);
        run_frame("f5_zero", 98);

        set_obj(0, 1, 6, 1, 3, 2, 24'h0000FF);
        run_frame("f6_pre_rst", 33);

        rst    = 1'b1;
        cfg_we = 1'b0;
        step();
        check_reset("rst_a");
        cfg_we    = 1'b1;
        cfg_addr  = 3'b011;
        cfg_wdata = 32'd1;
        step();
        check_reset("rst_b");
        cfg_addr  = 3'b001;
        cfg_wdata = (32'd3 << 16) | 32'd2;
        step();
        check_reset("rst_c");
        cfg_we = 1'b0;
        rst    = 1'b0;
        step();

        set_obj(0, 0, 0, 0, 0, 0, 24'h0);
        set_obj(1, 0, 0, 0, 0, 0, 24'h0);
        run_frame("f7_post_rst", 98);
        run_frame("f8_post_rst", 98);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_obj_renderer.md
# vga_obj_renderer

Parametrised VGA timing generator and N-object rectangle compositor. It sits between the LiteX SoC control outputs and the ADV7125 DAC pins, and supersedes the fixed single-colour VGA path. The SoC writes per-object position, size, colour and enable through a simple write port. All writes are staged in shadow registers and committed atomically at the frame boundary, so there is no tearing. Timing, polarity, object count and colour depth are parameters.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (lines)
- HS_POL / VS_POL, 0 / 0, active level of hsync and vsync
- N_OBJ, 4, number of objects (1..16); OAW = max(1, clog2(N_OBJ))
- CW, 8, bits per colour channel
- vga_clk  in  1  pixel clock; only clock
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  write strobe, one write per asserted cycle
- cfg_addr  in  OAW+2  [OAW+1:2] object index, [1:0] field: 0=pos, 1=size, 2=colour, 3=ctrl
- cfg_wdata  in  32  pos/size: [27:16]=x or w, [11:0]=y or h; colour: [3*CW-1:0]={r,g,b}; ctrl: [0]=enable
- bg_color  in  3*CW  background {r,g,b}, sampled every pixel
- vga_clk_out  out  1  pixel clock forwarded to DAC (ODDR-style, inverted)
- vga_hsync, vga_vsync  out  1  sync at programmed polarity
- vga_blank_n  out  1  high during active video
- vga_r, vga_g, vga_b  out  CW  pixel colour, zero when blanked
- frame_start  out  1  one-cycle pulse aligned with first active pixel output of each frame

## Operation
- Counters: h_cnt 0..H_TOT-1 (H_TOT=sum of H params), v_cnt 0..V_TOT-1, 12 bits each. v_cnt increments when h_cnt wraps. Both wrap to 0 together at the end of the frame.
- Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- hsync is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync uses the equivalent window on v_cnt.
- Shadow bank: cfg_we writes the selected field of the selected object. Index >= N_OBJ is ignored.
- Commit: on the cycle where h_cnt=H_TOT-1 and v_cnt=V_TOT-1, all shadow registers are copied to the active bank.
  - A write in that same cycle lands in shadow only and takes effect the next frame.
- Hit test for object i: enable & (x<=h_cnt<x+w) & (y<=v_cnt<y+h).
  - Sums are computed at 13 bits, so there is no wrap-around.
  - w=0 or h=0 gives no hit.
  - Objects extending past the active region are clipped.
- Priority: the lowest index wins. If no object hits, bg_color is used. Blanked pixels output 0.

## Timing
- Pipeline stage 0: counters. Stage 1: registered hit vector, active flag and sync flags. Stage 2: registered priority mux and outputs.
- Counter-to-pin latency is 2 cycles. Syncs, blank_n and frame_start are delayed identically so they stay aligned with the colour.
- A config write at cycle t is visible only from the next commit. Pixel latency after commit is 2 cycles.
- Reset values:
  - counters 0
  - hsync=~HS_POL, vsync=~VS_POL, blank_n=0
  - r/g/b=0, frame_start=0
  - all shadow and active registers 0 (objects disabled)
- The first valid output appears 2 cycles after rst deasserts: pixel (0,0) carries frame_start=1.
- Reset mid-frame: all of the above apply on the next edge. Pending shadow writes are lost.
- Simultaneous rst and cfg_we: reset wins.

## Test plan
Bench parameters: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2 (H_TOT=14); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOT=7); N_OBJ=2, CW=8; HS_POL=VS_POL=0.

- **Timing and sync:** release rst, bg_color=0x102030. Required response:
  - blank_n high for 8 of every 14 cycles
  - hsync low exactly at line positions 10..11
  - vsync low for all 14 cycles of line 5
  - frame period 98 cycles
  - frame_start at cycle 2 and at cycle 100
  - rgb=0x102030 when active, 0 when blanked
- **Single object:** write obj0 pos x=2,y=1, size w=3,h=2, colour 0xFF0000, enable=1 in frame 0. Required response:
  - frame 0 shows background only
  - frame 1 shows 0xFF0000 exactly at x 2..4, y 1..2
- **Priority:** obj0 at (2,1) 3x2 red; obj1 at (3,0) 4x4 colour 0x00FF00. Required response:
  - overlap pixels (3..4, 1..2) are red
  - the rest of obj1 is green
- **Commit boundary:** write obj0 colour 0x0000FF on the exact last cycle of frame 1. Required response:
  - frame 2 keeps the old colour
  - frame 3 shows blue
- **Clipping and zero size:** obj0 x=6, w=4090 → x 6..7 coloured, no wrap into x 0..5. Then obj0 w=0 → no pixels coloured.
- **Mid-frame reset:** assert rst at line 2 pixel 5. Required response:
  - outputs at reset values on the next edge
  - objects disabled
  - frame_start 2 cycles after release
